// File: rtl/tt_um_mascarenhas_toggle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_mascarenhas_toggle_decoder
// Description : Toggle-encoded event link receiver. It synchronises and
//               filters the line, regenerates one pulse per accepted toggle
//               and counts the accepted events.
// Revision    : 1.0
// ============================================================================
module tt_um_mascarenhas_toggle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int c_filt_w = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [c_filt_w-1:0]     filt_cnt_q, filt_cnt_d;
    logic                    level_q, level_d;
    logic                    pulse_q, pulse_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    glitch_q, glitch_d;

    logic w_s;
    logic w_accept;
    logic w_abort;
    logic w_clear;
    logic w_unused;

    assign w_s      = sync_q[SYNC_STAGES-1];
    assign w_clear  = ui_in[1];
    assign w_unused = &{1'b0, ena, ui_in[7:2], uio_in};

    always_comb begin
        // The raw line lands directly on the first synchroniser flop.
        sync_d     = {sync_q[SYNC_STAGES-2:0], ui_in[0]};
        state_d    = state_q;
        filt_cnt_d = filt_cnt_q;
        level_d    = level_q;
        pulse_d    = 1'b0;
        count_d    = count_q;
        ovf_d      = ovf_q;
        glitch_d   = glitch_q;
        w_accept   = 1'b0;
        w_abort    = 1'b0;

        case (state_q)
            ST_STABLE: begin
                filt_cnt_d = '0;
                if (w_s != level_q) begin
                    if (FILT_CYCLES == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        state_d    = ST_QUALIFY;
                        filt_cnt_d = c_filt_w'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (w_s != level_q) begin
                    if (filt_cnt_q == c_filt_last) begin
                        w_accept   = 1'b1;
                        state_d    = ST_STABLE;
                        filt_cnt_d = '0;
                    end else begin
                        filt_cnt_d = filt_cnt_q + 1'b1;
                    end
                end else begin
                    w_abort    = 1'b1;
                    state_d    = ST_STABLE;
                    filt_cnt_d = '0;
                end
            end
        endcase

        if (w_accept) begin
            level_d = ~level_q;
            pulse_d = 1'b1;
            count_d = count_q + 1'b1;
            if (&count_q) begin
                ovf_d = 1'b1;
            end
        end
        if (w_abort) begin
            glitch_d = 1'b1;
        end
        // Clear overrides the counter and stickies but leaves level/FSM/pulse alone.
        if (w_clear) begin
            count_d  = '0;
            ovf_d    = 1'b0;
            glitch_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STABLE;
            sync_q     <= '0;
            filt_cnt_q <= '0;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            glitch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            filt_cnt_q <= filt_cnt_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            glitch_q   <= glitch_d;
        end
    end

    assign uo_out  = {4'b0000, glitch_q, ovf_q, level_q, pulse_q};
    assign uio_out = count_q;
    assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_mascarenhas_toggle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_mascarenhas_toggle_decoder
// Description : Self-checking bench for the toggle-link receiver.
// Revision    : 1.0
// ============================================================================
module tb_tt_um_mascarenhas_toggle_decoder;

    localparam int SYNC = 2;
    localparam int FILT = 3;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    tt_um_mascarenhas_toggle_decoder #(
        .SYNC_STAGES(SYNC),
        .FILT_CYCLES(FILT),
        .CNT_W      (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: line delayed through the synchroniser, then accepted
    // once it has disagreed with the level for FILT consecutive samples.
    bit m_pipe[SYNC];
    bit m_lvl;
    int m_run;
    bit m_pulse;
    int m_cnt;
    bit m_ovf;
    bit m_glitch;

    function automatic void model_reset();
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
        m_lvl = 0; m_run = 0; m_pulse = 0; m_cnt = 0; m_ovf = 0; m_glitch = 0;
    endfunction

    function automatic void model_edge(input bit line, input bit clr);
        bit s;
        s = m_pipe[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = line;
        m_pulse = 0;
        if (s != m_lvl) begin
            m_run++;
            if (m_run == FILT) begin
                m_lvl   = ~m_lvl;
                m_pulse = 1;
                m_run   = 0;
                if (m_cnt == 255) m_ovf = 1;
                m_cnt = (m_cnt + 1) % 256;
            end
        end else begin
            if (m_run > 0) m_glitch = 1;
            m_run = 0;
        end
        if (clr) begin
            m_cnt = 0; m_ovf = 0; m_glitch = 0;
        end
    endfunction

    function automatic logic [7:0] model_uo();
        return {4'b0000, m_glitch, m_ovf, m_lvl, m_pulse};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".uo_out"}, uo_out, model_uo());
        check({tag, ".uio_out"}, uio_out, 8'(m_cnt));
        check({tag, ".uio_oe"}, uio_oe, 8'hFF);
    endtask

    // Drive after a falling edge, clock once, sample on the next falling edge.
    task automatic step(input bit line, input bit clr, input string tag);
        ui_in  = {6'($urandom), clr, line};
        uio_in = 8'($urandom);
        @(posedge clk);
        model_edge(line, clr);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        #1;
        model_reset();
        check("reset.uo_out", uo_out, 8'h00);
        check("reset.uio_out", uio_out, 8'h00);
        check("reset.uio_oe", uio_oe, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         line;
        bit         clr;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t tbl[13];
    bit   cur_line;

    initial begin
        // Per-edge vectors right after reset: entry 0 is edge 0.
        tbl[0]  = '{0, 0, 8'h00, 8'h00};
        tbl[1]  = '{1, 0, 8'h00, 8'h00};
        tbl[2]  = '{1, 0, 8'h00, 8'h00};
        tbl[3]  = '{1, 0, 8'h00, 8'h00};
        tbl[4]  = '{1, 0, 8'h00, 8'h00};
        tbl[5]  = '{1, 0, 8'h03, 8'h01};
        tbl[6]  = '{1, 0, 8'h02, 8'h01};
        tbl[7]  = '{0, 0, 8'h02, 8'h01};
        tbl[8]  = '{0, 0, 8'h02, 8'h01};
        tbl[9]  = '{0, 0, 8'h02, 8'h01};
        tbl[10] = '{0, 0, 8'h02, 8'h01};
        tbl[11] = '{0, 0, 8'h01, 8'h02};
        tbl[12] = '{0, 0, 8'h00, 8'h02};

        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        rst_n  = 1'b0;

        // Idle line after reset
        do_reset();
        repeat (20) step(1'b0, 1'b0, "idle");

        // Latency and both toggle directions
        do_reset();
        for (int i = 0; i < 13; i++) begin
            ui_in  = {6'b0, tbl[i].clr, tbl[i].line};
            uio_in = 8'h00;
            @(posedge clk);
            model_edge(tbl[i].line, tbl[i].clr);
            @(negedge clk);
            check($sformatf("tbl%0d.uo_out", i), uo_out, tbl[i].exp_uo);
            check($sformatf("tbl%0d.uio_out", i), uio_out, tbl[i].exp_uio);
        end

        // Short pulse rejected as a glitch, then cleared
        repeat (2) step(1'b1, 1'b0, "glitch");
        repeat (6) step(1'b0, 1'b0, "glitch");
        check("glitch.sticky", {7'b0, uo_out[3]}, 8'h01);
        check("glitch.count", uio_out, 8'h02);
        step(1'b0, 1'b1, "glitch_clr");
        check("glitch.cleared", {7'b0, uo_out[3]}, 8'h00);

        // Counter wrap and overflow sticky
        cur_line = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cur_line = ~cur_line;
            repeat (8) step(cur_line, 1'b0, "wrap");
        end
        check("wrap.count", uio_out, 8'h00);
        check("wrap.ovf", {7'b0, uo_out[2]}, 8'h01);
        cur_line = ~cur_line;
        repeat (8) step(cur_line, 1'b0, "wrap257");
        check("wrap257.count", uio_out, 8'h01);
        check("wrap257.ovf", {7'b0, uo_out[2]}, 8'h01);

        // Clear coincident with an accept at count 0x10
        step(cur_line, 1'b1, "pre_clr");
        for (int i = 0; i < 16; i++) begin
            cur_line = ~cur_line;
            repeat (8) step(cur_line, 1'b0, "fill");
        end
        check("fill.count", uio_out, 8'h10);
        cur_line = ~cur_line;
        repeat (4) step(cur_line, 1'b0, "acc_clr");
        step(cur_line, 1'b1, "acc_clr");
        check("acc_clr.pulse", {7'b0, uo_out[0]}, 8'h01);
        check("acc_clr.count", uio_out, 8'h00);
        check("acc_clr.level", {7'b0, uo_out[1]}, {7'b0, cur_line});
        repeat (3) step(cur_line, 1'b0, "acc_clr_post");

        // Randomised activity against the model
        for (int i = 0; i < 300; i++) begin
            int hold;
            hold = $urandom_range(1, 7);
            cur_line = ~cur_line;
            for (int k = 0; k < hold; k++)
                step(cur_line, ($urandom_range(0, 15) == 0), "rand");
        end
        repeat (8) step(cur_line, 1'b0, "settle");

        // Reset while qualifying a rising toggle
        cur_line = 1'b0;
        repeat (8) step(cur_line, 1'b0, "pre_rst");
        if (m_lvl) begin
            cur_line = 1'b1;
            repeat (8) step(cur_line, 1'b0, "pre_rst");
            cur_line = 1'b0;
            repeat (8) step(cur_line, 1'b0, "pre_rst");
        end
        step(1'b1, 1'b0, "pre_rst_toggle");
        check("pre_rst.count_nonzero", {7'b0, (uio_out != 8'h00)}, 8'h01);
        repeat (2) step(1'b1, 1'b0, "qualify");
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst.uo_out", uo_out, 8'h00);
        check("midrst.uio_out", uio_out, 8'h00);
        check("midrst.uio_oe", uio_oe, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, "post_rst");
            check($sformatf("post_rst%0d.pulse", k), {7'b0, uo_out[0]}, {7'b0, (k == 5)});
        end
        check("post_rst.level", {7'b0, uo_out[1]}, 8'h01);
        check("post_rst.count", uio_out, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
